mem_access_unit: RTL

- Parametrised next-generation MIPS MEM stage with an explicit memory handshake.
- Decodes the load/store opcode and generates byte enables and aligned store data.
- Detects AdEL/AdES (misalignment, out-of-range, illegal device writes) and drives one shared data port with req/ready wait-state handshake, stalling upstream while a slow access is outstanding.
- Sign/zero-extends load data and registers the result into the MEM/WB register; sits between the EX/MEM register and writeback, with DM and timer devices behind its port.

---
 rtl/mem_pkg.sv | 72 +++++++
 rtl/mem_addr_check.sv | 104 ++++++++++
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM state, default address
// map and the decode payload passed from mem_addr_check to mem_access_unit.
package mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned OPC_W = 6;

  // MIPS load/store major opcodes
  localparam logic [OPC_W-1:0] OPC_LB  = 6'h20;
  localparam logic [OPC_W-1:0] OPC_LH  = 6'h21;
  localparam logic [OPC_W-1:0] OPC_LW  = 6'h23;
  localparam logic [OPC_W-1:0] OPC_LBU = 6'h24;
  localparam logic [OPC_W-1:0] OPC_LHU = 6'h25;
  localparam logic [OPC_W-1:0] OPC_SB  = 6'h28;
  localparam logic [OPC_W-1:0] OPC_SH  = 6'h29;
  localparam logic [OPC_W-1:0] OPC_SW  = 6'h2B;

  // Default address map
  localparam logic [XLEN-1:0] RAM_LIMIT_DEF  = 32'h0000_2FFC;
  localparam logic [XLEN-1:0] DEV_BASE_DEF   = 32'h0000_7F00;
  localparam logic [XLEN-1:0] DEV_STRIDE_DEF = 32'h0000_0010;
  localparam int unsigned     DEV_NUM_DEF    = 2;
  localparam int unsigned     DEV_SIZE_DEF   = 12;
  localparam int unsigned     RO_OFFSET_DEF  = 8;
  localparam int unsigned     TIMEOUT_DEF    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    MOP_NONE,
    MOP_LB,
    MOP_LBU,
    MOP_LH,
    MOP_LHU,
    MOP_LW,
    MOP_SB,
    MOP_SH,
    MOP_SW
  } mop_t;

  // Decoded access: operation class, region and lane-prepared store data
  typedef struct packed {
    mop_t            op;
    logic            is_load;
    logic            is_store;
    logic            in_dev;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dec_t;

  function automatic mop_t decode_op(input logic [OPC_W-1:0] opc);
    mop_t op;
    case (opc)
      OPC_LB:  op = MOP_LB;
      OPC_LBU: op = MOP_LBU;
      OPC_LH:  op = MOP_LH;
      OPC_LHU: op = MOP_LHU;
      OPC_LW:  op = MOP_LW;
      OPC_SB:  op = MOP_SB;
      OPC_SH:  op = MOP_SH;
      OPC_SW:  op = MOP_SW;
      default: op = MOP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational access decode: region lookup (RAM / device windows),
// alignment, AdEL/AdES classification, byte enables and store lane data.
// Ports:
//   opcode  in   instruction major opcode
//   addr    in   effective byte address
//   wdata   in   raw store data
//   dec     out  decoded access payload (op, region, be, lane data)
//   adel    out  load address error, not gated by valid
//   ades    out  store address error, not gated by valid
module mem_addr_check
  import mem_pkg::*;
#(
  parameter logic [XLEN-1:0] RAM_LIMIT  = RAM_LIMIT_DEF,
  parameter int unsigned     DEV_NUM    = DEV_NUM_DEF,
  parameter logic [XLEN-1:0] DEV_BASE   = DEV_BASE_DEF,
  parameter logic [XLEN-1:0] DEV_STRIDE = DEV_STRIDE_DEF,
  parameter int unsigned     DEV_SIZE   = DEV_SIZE_DEF,
  parameter int unsigned     RO_OFFSET  = RO_OFFSET_DEF
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  output dec_t             dec,
  output logic             adel,
  output logic             ades
);

  localparam logic [XLEN-3:0] RO_WORD = (XLEN-2)'(RO_OFFSET >> 2);

  mop_t            op;
  logic            in_ram;
  logic            in_dev;
  logic            mapped;
  logic            ro_hit;
  logic            mis_h;
  logic            mis_w;
  logic [XLEN-1:0] win_base;
  logic [XLEN-1:0] dev_off;

  assign op     = decode_op(opcode);
  assign in_ram = (addr[XLEN-1:2] <= RAM_LIMIT[XLEN-1:2]);
  assign mapped = in_ram | in_dev;
  assign mis_h  = addr[0];
  assign mis_w  = |addr[1:0];
  assign ro_hit = in_dev & (dev_off[XLEN-1:2] == RO_WORD);

  // Device window lookup; windows never overlap so the last hit wins harmlessly
  always_comb begin
    in_dev   = 1'b0;
    dev_off  = '0;
    win_base = '0;
    for (int unsigned k = 0; k < DEV_NUM; k++) begin
      win_base = DEV_BASE + DEV_STRIDE * XLEN'(k);
      if ((addr >= win_base) && ((addr - win_base) < XLEN'(DEV_SIZE))) begin
        in_dev  = 1'b1;
        dev_off = addr - win_base;
      end
    end
  end

  // Error classification, byte enables and lane replication
  always_comb begin
    adel         = 1'b0;
    ades         = 1'b0;
    dec.op       = op;
    dec.is_load  = 1'b0;
    dec.is_store = 1'b0;
    dec.in_dev   = in_dev;
    dec.be       = 4'b1111;
    dec.wdata    = wdata;
    case (op)
      MOP_LB, MOP_LBU: begin
        dec.is_load = 1'b1;
        adel        = ~in_ram;
      end
      MOP_LH, MOP_LHU: begin
        dec.is_load = 1'b1;
        adel        = mis_h | ~in_ram;
      end
      MOP_LW: begin
        dec.is_load = 1'b1;
        adel        = mis_w | ~mapped;
      end
      MOP_SB: begin
        dec.is_store = 1'b1;
        ades         = ~mapped | in_dev | ro_hit;
        dec.be       = BE_W'(1) << addr[1:0];
        dec.wdata    = {4{wdata[7:0]}};
      end
      MOP_SH: begin
        dec.is_store = 1'b1;
        ades         = mis_h | ~mapped | in_dev | ro_hit;
        dec.be       = addr[1] ? 4'b1100 : 4'b0011;
        dec.wdata    = {2{wdata[15:0]}};
      end
      MOP_SW: begin
        dec.is_store = 1'b1;
        ades         = mis_w | ~mapped | ro_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: issues loads/stores on a single req/ready data port,
// stalls upstream during wait states, flags AdEL/AdES, extends load data
// and holds the MEM/WB pipeline register.
// Optional feature macro: MEM_TIMEOUT_EN (adds a WAIT-state timeout and the
// bus_err output).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   valid_i .. wa_i        EX/MEM register contents
//   int_req                squash request from exception logic
//   adel, ades             combinational address errors
//   stall                  freeze upstream stages
//   mem_req .. mem_dev     data-port request side
//   mem_rdata, mem_ready   data-port response side
//   valid_o .. result_o    MEM/WB register
//   bus_err                one-cycle timeout pulse (MEM_TIMEOUT_EN only)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [XLEN-1:0] RAM_LIMIT  = RAM_LIMIT_DEF,
  parameter int unsigned     DEV_NUM    = DEV_NUM_DEF,
  parameter logic [XLEN-1:0] DEV_BASE   = DEV_BASE_DEF,
  parameter logic [XLEN-1:0] DEV_STRIDE = DEV_STRIDE_DEF,
  parameter int unsigned     DEV_SIZE   = DEV_SIZE_DEF,
  parameter int unsigned     RO_OFFSET  = RO_OFFSET_DEF,
  parameter int unsigned     TIMEOUT    = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RA_W-1:0] wa_i,
  input  logic            int_req,
  output logic            adel,
  output logic            ades,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_dev,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic [RA_W-1:0] wa_o,
  output logic [XLEN-1:0] rd_o,
  output logic [XLEN-1:0] result_o
`ifdef MEM_TIMEOUT_EN
  ,
  output logic            bus_err
`endif
);

  dec_t            dec;
  logic            adel_raw;
  logic            ades_raw;
  logic            issue;
  logic            timeout_c;
  logic            int_eff;
  logic            wb_valid;
  state_t          state;
  state_t          state_nxt;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] rd_nxt;

  mem_addr_check #(
    .RAM_LIMIT  (RAM_LIMIT),
    .DEV_NUM    (DEV_NUM),
    .DEV_BASE   (DEV_BASE),
    .DEV_STRIDE (DEV_STRIDE),
    .DEV_SIZE   (DEV_SIZE),
    .RO_OFFSET  (RO_OFFSET)
  ) u_check (
    .opcode (instr_i[XLEN-1:XLEN-OPC_W]),
    .addr   (addr_i),
    .wdata  (wdata_i),
    .dec    (dec),
    .adel   (adel_raw),
    .ades   (ades_raw)
  );

  assign adel  = valid_i & adel_raw;
  assign ades  = valid_i & ades_raw;
  assign issue = valid_i & (dec.is_load | dec.is_store) & ~adel_raw & ~ades_raw & ~int_req;

  assign mem_addr  = {addr_i[XLEN-1:2], 2'b00};
  assign mem_be    = dec.be;
  assign mem_wdata = dec.wdata;
  assign mem_dev   = dec.in_dev;
  assign mem_we    = mem_req & dec.is_store;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // The IDLE request cycle counts as the first stalled cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_c = (state == ST_WAIT) & ~mem_ready & (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout_c;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue && !mem_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_ready || timeout_c) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: request is held through WAIT, a timeout releases the pipe
  always_comb begin
    mem_req = 1'b0;
    stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_req = issue;
        stall   = issue & ~mem_ready;
      end
      ST_WAIT: begin
        mem_req = ~timeout_c;
        stall   = ~mem_ready & ~timeout_c;
      end
      default: ;
    endcase
  end

  // An interrupt only squashes an instruction that has not started its access
  assign int_eff  = int_req & (state == ST_IDLE);
  assign wb_valid = valid_i & ~int_eff & ~adel_raw & ~ades_raw & ~timeout_c;

  // Load lane select and extension
  always_comb begin
    case (addr_i[1:0])
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_i[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rd_nxt = '0;
    case (dec.op)
      MOP_LB:  rd_nxt = {{24{lane_b[7]}}, lane_b};
      MOP_LBU: rd_nxt = {24'd0, lane_b};
      MOP_LH:  rd_nxt = {{16{lane_h[15]}}, lane_h};
      MOP_LHU: rd_nxt = {16'd0, lane_h};
      MOP_LW:  rd_nxt = mem_rdata;
      default: rd_nxt = '0;
    endcase
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o  <= 1'b0;
      pc_o     <= '0;
      instr_o  <= '0;
      wa_o     <= '0;
      rd_o     <= '0;
      result_o <= '0;
    end else if (!stall) begin
      valid_o  <= wb_valid;
      pc_o     <= pc_i;
      instr_o  <= instr_i;
      wa_o     <= wb_valid ? wa_i : '0;
      rd_o     <= rd_nxt;
      result_o <= addr_i;
    end
  end

endmodule
